decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I/RV64I decode stage sitting between fetch and execute in the single-cycle-to-pipelined datapath. It accepts instruction+PC over a valid/ready handshake and decodes the full base integer opcode set: load, op-imm, op, store, branch, jal, jalr, lui, auipc. It produces the existing control-bundle encoding plus B/U/J immediates and an illegal-instruction flag. Output is registered, with a one-entry skid buffer so in_ready is a pure register output.

Parameters:
XLEN, 32, datapath and immediate width; 32 or 64; controls sign-extension width and LD legality.
ZERO_RD_SUPPRESS, 1, when 1, regWrite is forced 0 if rd==0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  drop all held and incoming instructions
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; equals ~skid_valid
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  XLEN  PC of decoded instruction
out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J); 0 for R-type
out_rs1, out_rs2, out_rd  out  5 each  register fields (raw bit slices)
out_regWrite, out_memToReg, out_memWrite, out_branch, out_jalrEN, out_jalEN  out  1 each  control strobes
out_operandA  out  1  1 = immediate selected as ALU second operand
out_operandB  out  1  1 = PC selected as ALU first operand (auipc, jal)
out_aluOP  out  6  operation code
out_illegal  out  1  instruction not decodable

Behaviour:
- Reset: every output 0, except in_ready=1; skid_valid=0; inputs ignored while rst high.
- Latency: accept at edge N -> out_valid at edge N+1.
- Output register loads when ~out_valid | out_ready; source is skid entry if skid_valid, else input.
- Input accepted when in_valid & in_ready. If the output register is stalled (out_valid & ~out_ready), the accepted word goes to skid. Skid drains into the output on the next out_ready.
- Ordering is strictly preserved; no bubble under continuous out_ready.
- flush: out_valid and skid_valid cleared at the next edge; an input accepted in the flush cycle is discarded; flush wins over all other events.
- aluOP codes:
  - loads: LB0 LH1 LW2 LD3 LBU4 LHU14
  - op-imm: ADDI5 SLLI6 SLTI7 SLTIU8 XORI9 SRLI10 SRAI11 ORI12 ANDI13
  - stores: SB15 SH16 SW17
  - op: ADD18 SUB19 SLL20 SLT21 SLTU22 XOR23 SRL24 SRA25 OR26 AND27
  - branches: BEQ28 BNE29 BLT30 BGE31 BLTU32 BGEU33
  - JAL34 JALR35 LUI36 AUIPC37
- Control per class:
  - load: regWrite, memToReg, operandA
  - op-imm: regWrite, operandA
  - op: regWrite
  - store: memWrite, operandA
  - branch: branch
  - jal: regWrite, jalEN, operandA, operandB
  - jalr: regWrite, jalrEN, operandA
  - lui: regWrite, operandA
  - auipc: regWrite, operandA, operandB
- Illegal when any of:
  - unknown opcode
  - load func3 in {6,7}, or func3=3 with XLEN=32
  - store func3 > 2
  - branch func3 in {2,3}
  - op func7 not 0x00/0x20, or 0x20 with func3 not in {0,5}
  - SLLI/SRLI with func7 != 0; SRAI with func7 != 0x20
  - jalr func3 != 0
- On illegal: out_illegal=1, all control strobes and aluOP = 0, out_valid still asserted.
- Immediates are sign-extended from instr[31] to XLEN; U-imm = {instr[31:12], 12'b0} sign-extended.

Decomposition:
- Shared include decode_defs.vh: opcode localparams, all aluOP codes, and the immediate-type enum.
- One combinational sub-module, rv_decode_comb: instr -> bundle. It is instantiated once, on the muxed source feeding the output register; the skid buffer stores raw instr+pc only.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, aluOP=5, imm=5, rd=1, regWrite=1, operandA=1.
- 0x0020A423 (sw x2,8(x1)) -> aluOP=17, imm=8, memWrite=1, regWrite=0, rs1=1, rs2=2.
- 0xFE208EE3 (beq x1,x2,-4) -> aluOP=28, branch=1, imm=0xFFFFFFFC. Then 0x010000EF (jal x1,+16) -> aluOP=34, jalEN=1, imm=16, operandB=1. Then 0x123452B7 (lui) -> imm=0x12345000, aluOP=36.
- Backpressure: out_ready=0 with 3 back-to-back valid inputs -> second lands in skid, in_ready=0, third held upstream. out_ready=1 -> all three emerge in order, no loss or duplication.
- Illegal/zero-rd: 0x4000F033 (func7=0x20, func3=7) -> illegal=1, regWrite=0, aluOP=0. Then 0x00500013 (addi x0,x0,5) -> regWrite=0 with ZERO_RD_SUPPRESS=1.
- flush asserted while skid and output are both full, and rst asserted mid-stream -> out_valid=0 and in_ready=1 next edge (flush) / immediately (rst); no stale bundle appears afterwards.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, immediate formats
// and the control bundle carried from the decoder to the output register.
package decode_stage_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic [5:0] ALU_LB    = 6'd0;
   localparam logic [5:0] ALU_LH    = 6'd1;
   localparam logic [5:0] ALU_LW    = 6'd2;
   localparam logic [5:0] ALU_LD    = 6'd3;
   localparam logic [5:0] ALU_LBU   = 6'd4;
   localparam logic [5:0] ALU_ADDI  = 6'd5;
   localparam logic [5:0] ALU_SLLI  = 6'd6;
   localparam logic [5:0] ALU_SLTI  = 6'd7;
   localparam logic [5:0] ALU_SLTIU = 6'd8;
   localparam logic [5:0] ALU_XORI  = 6'd9;
   localparam logic [5:0] ALU_SRLI  = 6'd10;
   localparam logic [5:0] ALU_SRAI  = 6'd11;
   localparam logic [5:0] ALU_ORI   = 6'd12;
   localparam logic [5:0] ALU_ANDI  = 6'd13;
   localparam logic [5:0] ALU_LHU   = 6'd14;
   localparam logic [5:0] ALU_SB    = 6'd15;
   localparam logic [5:0] ALU_SH    = 6'd16;
   localparam logic [5:0] ALU_SW    = 6'd17;
   localparam logic [5:0] ALU_ADD   = 6'd18;
   localparam logic [5:0] ALU_SUB   = 6'd19;
   localparam logic [5:0] ALU_SLL   = 6'd20;
   localparam logic [5:0] ALU_SLT   = 6'd21;
   localparam logic [5:0] ALU_SLTU  = 6'd22;
   localparam logic [5:0] ALU_XOR   = 6'd23;
   localparam logic [5:0] ALU_SRL   = 6'd24;
   localparam logic [5:0] ALU_SRA   = 6'd25;
   localparam logic [5:0] ALU_OR    = 6'd26;
   localparam logic [5:0] ALU_AND   = 6'd27;
   localparam logic [5:0] ALU_BEQ   = 6'd28;
   localparam logic [5:0] ALU_BNE   = 6'd29;
   localparam logic [5:0] ALU_BLT   = 6'd30;
   localparam logic [5:0] ALU_BGE   = 6'd31;
   localparam logic [5:0] ALU_BLTU  = 6'd32;
   localparam logic [5:0] ALU_BGEU  = 6'd33;
   localparam logic [5:0] ALU_JAL   = 6'd34;
   localparam logic [5:0] ALU_JALR  = 6'd35;
   localparam logic [5:0] ALU_LUI   = 6'd36;
   localparam logic [5:0] ALU_AUIPC = 6'd37;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   typedef struct packed {
      logic       regWrite;
      logic       memToReg;
      logic       memWrite;
      logic       branch;
      logic       jalrEN;
      logic       jalEN;
      logic       operandA;
      logic       operandB;
      logic [5:0] aluOP;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side instruction handshake and execute-side decoded bundle of the
// decode stage; slave is the stage itself, master is its environment.
interface decode_stage_if #(parameter int XLEN = 32);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic            out_regWrite;
   logic            out_memToReg;
   logic            out_memWrite;
   logic            out_branch;
   logic            out_jalrEN;
   logic            out_jalEN;
   logic            out_operandA;
   logic            out_operandB;
   logic [5:0]      out_aluOP;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_regWrite, out_memToReg, out_memWrite, out_branch, out_jalrEN,
             out_jalEN, out_operandA, out_operandB, out_aluOP, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_regWrite, out_memToReg, out_memWrite, out_branch, out_jalrEN,
             out_jalEN, out_operandA, out_operandB, out_aluOP, out_illegal
   );

endinterface

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I/RV64I base-integer decoder: instruction word in,
// control bundle, sign-extended immediate and raw register fields out.
module rv_decode_comb
   import decode_stage_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
   input  logic [31:0]     instr_i,
   output ctrl_t           ctrl_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [6:0] sh_f7;
   ctrl_t      c;
   logic       bad;
   imm_type_e  itype;
   logic [31:0] imm32;

   function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   assign f7    = instr_i[31:25];
   assign rs1_o = instr_i[19:15];
   assign rs2_o = instr_i[24:20];
   assign rd_o  = instr_i[11:7];
   // RV64 shift amounts are six bits wide, so instr[25] belongs to shamt there
   assign sh_f7 = (XLEN == 64) ? {instr_i[31:26], 1'b0} : instr_i[31:25];

   always_comb begin
      c     = '0;
      bad   = 1'b0;
      itype = IMM_NONE;
      case (opc)
         OPC_LOAD: begin
            {c.regWrite, c.memToReg, c.operandA} = 3'b111;
            itype = IMM_I;
            case (f3)
               3'd0: c.aluOP = ALU_LB;
               3'd1: c.aluOP = ALU_LH;
               3'd2: c.aluOP = ALU_LW;
               3'd3: if (XLEN == 64) c.aluOP = ALU_LD; else bad = 1'b1;
               3'd4: c.aluOP = ALU_LBU;
               3'd5: c.aluOP = ALU_LHU;
               default: bad = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            {c.regWrite, c.operandA} = 2'b11;
            itype = IMM_I;
            case (f3)
               3'd0: c.aluOP = ALU_ADDI;
               3'd1: begin
                  c.aluOP = ALU_SLLI;
                  bad     = (sh_f7 != 7'h00);
               end
               3'd2: c.aluOP = ALU_SLTI;
               3'd3: c.aluOP = ALU_SLTIU;
               3'd4: c.aluOP = ALU_XORI;
               3'd5: begin
                  if (sh_f7 == 7'h00)      c.aluOP = ALU_SRLI;
                  else if (sh_f7 == 7'h20) c.aluOP = ALU_SRAI;
                  else                     bad = 1'b1;
               end
               3'd6: c.aluOP = ALU_ORI;
               default: c.aluOP = ALU_ANDI;
            endcase
         end
         OPC_STORE: begin
            {c.memWrite, c.operandA} = 2'b11;
            itype = IMM_S;
            case (f3)
               3'd0: c.aluOP = ALU_SB;
               3'd1: c.aluOP = ALU_SH;
               3'd2: c.aluOP = ALU_SW;
               default: bad = 1'b1;
            endcase
         end
         OPC_OP: begin
            c.regWrite = 1'b1;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: c.aluOP = ALU_ADD;
                  3'd1: c.aluOP = ALU_SLL;
                  3'd2: c.aluOP = ALU_SLT;
                  3'd3: c.aluOP = ALU_SLTU;
                  3'd4: c.aluOP = ALU_XOR;
                  3'd5: c.aluOP = ALU_SRL;
                  3'd6: c.aluOP = ALU_OR;
                  default: c.aluOP = ALU_AND;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
               c.aluOP = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               c.aluOP = ALU_SRA;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_BRANCH: begin
            c.branch = 1'b1;
            itype    = IMM_B;
            case (f3)
               3'd0: c.aluOP = ALU_BEQ;
               3'd1: c.aluOP = ALU_BNE;
               3'd4: c.aluOP = ALU_BLT;
               3'd5: c.aluOP = ALU_BGE;
               3'd6: c.aluOP = ALU_BLTU;
               3'd7: c.aluOP = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_JAL: begin
            {c.regWrite, c.jalEN, c.operandA, c.operandB} = 4'b1111;
            c.aluOP = ALU_JAL;
            itype   = IMM_J;
         end
         OPC_JALR: begin
            {c.regWrite, c.jalrEN, c.operandA} = 3'b111;
            c.aluOP = ALU_JALR;
            itype   = IMM_I;
            bad     = (f3 != 3'd0);
         end
         OPC_LUI: begin
            {c.regWrite, c.operandA} = 2'b11;
            c.aluOP = ALU_LUI;
            itype   = IMM_U;
         end
         OPC_AUIPC: begin
            {c.regWrite, c.operandA, c.operandB} = 3'b111;
            c.aluOP = ALU_AUIPC;
            itype   = IMM_U;
         end
         default: bad = 1'b1;
      endcase

      if (bad) begin
         c         = '0;
         c.illegal = 1'b1;
      end
      if (ZERO_RD_SUPPRESS && rd_o == 5'd0) c.regWrite = 1'b0;
      ctrl_o = c;
   end

   always_comb begin
      imm32 = '0;
      case (itype)
         IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U: imm32 = {instr_i[31:12], 12'b0};
         IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm_o = sext(imm32);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a one-entry skid buffer holding raw instr+pc,
// so in_ready comes straight from a flop and full throughput is sustained.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   decode_stage_if.slave bus
);

   logic            skid_valid_q, skid_valid_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic [4:0]      out_rs1_q, out_rs1_d;
   logic [4:0]      out_rs2_q, out_rs2_d;
   logic [4:0]      out_rd_q, out_rd_d;
   ctrl_t           out_ctrl_q, out_ctrl_d;

   logic            accept, out_load, src_valid;
   logic [31:0]     src_instr;
   logic [XLEN-1:0] src_pc;
   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1, dec_rs2, dec_rd;

   assign accept    = bus.in_valid & ~skid_valid_q;
   assign out_load  = ~out_valid_q | bus.out_ready;
   assign src_valid = skid_valid_q | accept;
   // The skid entry is always older than the input, so it has priority
   assign src_instr = skid_valid_q ? skid_instr_q : bus.in_instr;
   assign src_pc    = skid_valid_q ? skid_pc_q : bus.in_pc;

   rv_decode_comb #(
      .XLEN             (XLEN),
      .ZERO_RD_SUPPRESS (ZERO_RD_SUPPRESS)
   ) u_dec (
      .instr_i (src_instr),
      .ctrl_o  (dec_ctrl),
      .imm_o   (dec_imm),
      .rs1_o   (dec_rs1),
      .rs2_o   (dec_rs2),
      .rd_o    (dec_rd)
   );

   always_comb begin
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_imm_d    = out_imm_q;
      out_rs1_d    = out_rs1_q;
      out_rs2_d    = out_rs2_q;
      out_rd_d     = out_rd_q;
      out_ctrl_d   = out_ctrl_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_load) begin
         out_valid_d  = src_valid;
         skid_valid_d = 1'b0;
         if (src_valid) begin
            out_pc_d   = src_pc;
            out_imm_d  = dec_imm;
            out_rs1_d  = dec_rs1;
            out_rs2_d  = dec_rs2;
            out_rd_d   = dec_rd;
            out_ctrl_d = dec_ctrl;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_instr_d = bus.in_instr;
         skid_pc_d    = bus.in_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_imm_q    <= '0;
         out_rs1_q    <= '0;
         out_rs2_q    <= '0;
         out_rd_q     <= '0;
         out_ctrl_q   <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_imm_q    <= out_imm_d;
         out_rs1_q    <= out_rs1_d;
         out_rs2_q    <= out_rs2_d;
         out_rd_q     <= out_rd_d;
         out_ctrl_q   <= out_ctrl_d;
      end
   end

   assign bus.in_ready     = ~skid_valid_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_pc       = out_pc_q;
   assign bus.out_imm      = out_imm_q;
   assign bus.out_rs1      = out_rs1_q;
   assign bus.out_rs2      = out_rs2_q;
   assign bus.out_rd       = out_rd_q;
   assign bus.out_regWrite = out_ctrl_q.regWrite;
   assign bus.out_memToReg = out_ctrl_q.memToReg;
   assign bus.out_memWrite = out_ctrl_q.memWrite;
   assign bus.out_branch   = out_ctrl_q.branch;
   assign bus.out_jalrEN   = out_ctrl_q.jalrEN;
   assign bus.out_jalEN    = out_ctrl_q.jalEN;
   assign bus.out_operandA = out_ctrl_q.operandA;
   assign bus.out_operandB = out_ctrl_q.operandB;
   assign bus.out_aluOP    = out_ctrl_q.aluOP;
   assign bus.out_illegal  = out_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan sequences plus randomized traffic,
// checked every cycle against a queue-based behavioural model of the stage.
module tb_decode_stage;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(XLEN)) bus();

   decode_stage #(
      .XLEN             (XLEN),
      .ZERO_RD_SUPPRESS (1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        rw, m2r, mw, br, jalr, jal, opA, opB;
      logic [5:0]  alu;
      logic        ill;
      logic [31:0] imm;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   txn_t q[$];

   int load_t  [8] = '{0, 1, 2, -1, 4, 14, -1, -1};
   int opimm_t [8] = '{5, 6, 7, 8, 9, 10, 12, 13};
   int op_t    [8] = '{18, 20, 21, 22, 23, 24, 26, 27};
   int br_t    [8] = '{28, 29, -1, -1, 30, 31, 32, 33};
   logic [6:0] opc_t [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode written from the instruction-set tables, not the RTL
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int f3, f7, t;
      bit ill;
      logic signed [31:0] sw, hi_s, hi_b;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      e     = '0;
      ill   = 1'b0;
      t     = 0;
      f3    = int'(w[14:12]);
      f7    = int'(w[31:25]);
      sw    = w;
      hi_s  = sw >>> 25;
      hi_b  = sw >>> 31;
      imm_i = sw >>> 20;
      imm_s = (hi_s << 5) | w[11:7];
      imm_b = (hi_b << 12) | (w[7] << 11) | (w[30:25] << 5) | (w[11:8] << 1);
      imm_u = w & 32'hFFFF_F000;
      imm_j = (hi_b << 20) | (w[19:12] << 12) | (w[20] << 11) | (w[30:21] << 1);
      case (w[6:0])
         7'h03: begin
            t = load_t[f3]; ill = (t < 0);
            e.rw = 1; e.m2r = 1; e.opA = 1; e.imm = imm_i;
         end
         7'h13: begin
            t = opimm_t[f3];
            if (f3 == 1 && f7 != 0) ill = 1;
            if (f3 == 5) begin
               if (f7 == 32) t = 11;
               else if (f7 != 0) ill = 1;
            end
            e.rw = 1; e.opA = 1; e.imm = imm_i;
         end
         7'h33: begin
            if (f7 == 0) t = op_t[f3];
            else if (f7 == 32 && f3 == 0) t = 19;
            else if (f7 == 32 && f3 == 5) t = 25;
            else ill = 1;
            e.rw = 1;
         end
         7'h23: begin
            ill = (f3 > 2); t = 15 + f3;
            e.mw = 1; e.opA = 1; e.imm = imm_s;
         end
         7'h63: begin
            t = br_t[f3]; ill = (t < 0);
            e.br = 1; e.imm = imm_b;
         end
         7'h6F: begin
            t = 34; e.rw = 1; e.jal = 1; e.opA = 1; e.opB = 1; e.imm = imm_j;
         end
         7'h67: begin
            t = 35; ill = (f3 != 0); e.rw = 1; e.jalr = 1; e.opA = 1; e.imm = imm_i;
         end
         7'h37: begin
            t = 36; e.rw = 1; e.opA = 1; e.imm = imm_u;
         end
         7'h17: begin
            t = 37; e.rw = 1; e.opA = 1; e.opB = 1; e.imm = imm_u;
         end
         default: ill = 1;
      endcase
      e.alu = t[5:0];
      if (ill) begin
         e     = '0;
         e.ill = 1'b1;
      end
      if (w[11:7] == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   function automatic logic [14:0] ctl_of(input exp_t e);
      return {e.rw, e.m2r, e.mw, e.br, e.jalr, e.jal, e.opA, e.opB, e.alu, e.ill};
   endfunction

   function automatic logic [14:0] dut_ctl();
      return {bus.out_regWrite, bus.out_memToReg, bus.out_memWrite, bus.out_branch,
              bus.out_jalrEN, bus.out_jalEN, bus.out_operandA, bus.out_operandB,
              bus.out_aluOP, bus.out_illegal};
   endfunction

   exp_t ce;
   txn_t ct;
   bit   cov, cir;

   // Per-cycle compare against the model; handshakes are resolved here too
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_in_ready", bus.in_ready, 1);
         chk("rst_ctrl", dut_ctl(), 0);
         chk("rst_imm", bus.out_imm, 0);
         chk("rst_pc", bus.out_pc, 0);
         chk("rst_regs", {bus.out_rs1, bus.out_rs2, bus.out_rd}, 0);
      end else begin
         cov = (q.size() > 0);
         cir = (q.size() < 2);
         chk("out_valid", bus.out_valid, cov);
         chk("in_ready", bus.in_ready, cir);
         if (cov) begin
            ce = model(q[0].instr);
            chk("ctrl", dut_ctl(), ctl_of(ce));
            if (!ce.ill) chk("imm", bus.out_imm, ce.imm);
            chk("pc", bus.out_pc, q[0].pc);
            chk("regs", {bus.out_rs1, bus.out_rs2, bus.out_rd},
                {q[0].instr[19:15], q[0].instr[24:20], q[0].instr[11:7]});
         end
         if (flush) begin
            q.delete();
         end else begin
            if (cov && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && cir) begin
               ct.instr = bus.in_instr;
               ct.pc    = bus.in_pc;
               q.push_back(ct);
            end
         end
      end
   end

   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      flush         = fl;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 99) < 85) w[6:0] = opc_t[$urandom_range(0, 8)];
      if ($urandom_range(0, 99) < 70) w[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
      return w;
   endfunction

   exp_t me;

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;

      me = model(32'h0050_0093);
      chk("model_addi", {me.alu, me.rw, me.opA, me.imm}, {6'd5, 1'b1, 1'b1, 32'd5});
      me = model(32'hFE20_8EE3);
      chk("model_beq", {me.alu, me.br, me.imm}, {6'd28, 1'b1, 32'hFFFF_FFFC});
      me = model(32'h0100_00EF);
      chk("model_jal", {me.alu, me.jal, me.opB, me.imm}, {6'd34, 1'b1, 1'b1, 32'd16});
      me = model(32'h4000_F033);
      chk("model_illegal", {me.ill, me.alu, me.rw}, {1'b1, 6'd0, 1'b0});

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // addi x1,x0,5
      step(1, 32'h0050_0093, 32'h1000, 1, 0);
      idle();
      @(negedge clk);
      chk("addi_valid", bus.out_valid, 1);
      chk("addi_alu", bus.out_aluOP, 5);
      chk("addi_imm", bus.out_imm, 5);
      chk("addi_rd", bus.out_rd, 1);
      chk("addi_rw_opa", {bus.out_regWrite, bus.out_operandA}, 2'b11);

      // sw x2,8(x1)
      step(1, 32'h0020_A423, 32'h1004, 1, 0);
      idle();
      @(negedge clk);
      chk("sw_alu", bus.out_aluOP, 17);
      chk("sw_imm", bus.out_imm, 8);
      chk("sw_mw_rw", {bus.out_memWrite, bus.out_regWrite}, 2'b10);
      chk("sw_rs", {bus.out_rs1, bus.out_rs2}, {5'd1, 5'd2});

      // beq, jal, lui back to back
      step(1, 32'hFE20_8EE3, 32'h1008, 1, 0);
      step(1, 32'h0100_00EF, 32'h100C, 1, 0);
      @(negedge clk);
      chk("beq_alu", bus.out_aluOP, 28);
      chk("beq_branch", bus.out_branch, 1);
      chk("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
      step(1, 32'h1234_52B7, 32'h1010, 1, 0);
      @(negedge clk);
      chk("jal_alu", bus.out_aluOP, 34);
      chk("jal_en_opb", {bus.out_jalEN, bus.out_operandB}, 2'b11);
      chk("jal_imm", bus.out_imm, 16);
      idle();
      @(negedge clk);
      chk("lui_imm", bus.out_imm, 32'h1234_5000);
      chk("lui_alu", bus.out_aluOP, 36);

      // backpressure: three addi's with the output stalled
      step(1, 32'h0010_0093, 32'h100, 0, 0);
      step(1, 32'h0020_0113, 32'h104, 0, 0);
      @(negedge clk);
      chk("bp_pc_a", bus.out_pc, 32'h100);
      chk("bp_rdy_a", bus.in_ready, 1);
      step(1, 32'h0030_0193, 32'h108, 0, 0);
      @(negedge clk);
      chk("bp_rdy_full", bus.in_ready, 0);
      chk("bp_pc_b", bus.out_pc, 32'h100);
      step(1, 32'h0030_0193, 32'h108, 1, 0);
      @(negedge clk);
      chk("bp_pc_c", bus.out_pc, 32'h100);
      step(1, 32'h0030_0193, 32'h108, 1, 0);
      @(negedge clk);
      chk("bp_pc_d", bus.out_pc, 32'h104);
      chk("bp_rd_d", bus.out_rd, 2);
      idle();
      @(negedge clk);
      chk("bp_pc_e", bus.out_pc, 32'h108);
      chk("bp_rd_e", bus.out_rd, 3);
      idle();
      @(negedge clk);
      chk("bp_drained", bus.out_valid, 0);

      // illegal op, then addi to x0
      step(1, 32'h4000_F033, 32'h2000, 1, 0);
      step(1, 32'h0050_0013, 32'h2004, 1, 0);
      @(negedge clk);
      chk("ill_flag", {bus.out_valid, bus.out_illegal}, 2'b11);
      chk("ill_rw_alu", {bus.out_regWrite, bus.out_aluOP}, 7'd0);
      idle();
      @(negedge clk);
      chk("x0_rw", bus.out_regWrite, 0);
      chk("x0_alu", {bus.out_aluOP, bus.out_illegal}, {6'd5, 1'b0});

      // flush with output and skid both full
      step(1, 32'h0010_0093, 32'h3000, 0, 0);
      step(1, 32'h0020_0113, 32'h3004, 0, 0);
      step(1, 32'h0030_0193, 32'h3008, 0, 1);
      @(negedge clk);
      chk("fl_pre", {bus.out_valid, bus.in_ready}, 2'b10);
      step(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      chk("fl_post", {bus.out_valid, bus.in_ready}, 2'b01);
      idle();
      @(negedge clk);
      chk("fl_nostale", bus.out_valid, 0);

      // asynchronous reset mid-stream
      step(1, 32'h0010_0093, 32'h4000, 0, 0);
      step(1, 32'h0020_0113, 32'h4004, 0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_async", {bus.out_valid, bus.in_ready}, 2'b01);
      step(1, 32'h0030_0193, 32'h4008, 1, 0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_nostale", bus.out_valid, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst           = ($urandom_range(0, 199) == 0);
         flush         = ($urandom_range(0, 29) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_instr  = rand_instr();
         bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) idle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
